// File: rtl/wb_stage.sv
// Write-back stage: latches the MEM-stage instruction, selects write data and owns HI/LO.
// Optional retire counter (retired_count) is enabled by defining WB_RETIRE_COUNT_EN.
module wb_stage #(
    parameter bit          ZERO_R0 = 1'b1,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      mem_instruction,
    input  logic             mem_valid,
    input  logic [31:0]      alu_result,
    input  logic [31:0]      mem_rdata,
    input  logic [31:0]      md_hi,
    input  logic [31:0]      md_lo,
    input  logic             md_done,
    output logic             stall,
    output logic [31:0]      WBInstruction,
    output logic [31:0]      DataOut,
    output logic             md_busy
`ifdef WB_RETIRE_COUNT_EN
    ,
    output logic [CNT_W-1:0] retired_count
`endif
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OP_W  = 6;
    localparam int unsigned REG_W = 5;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;

    localparam logic [OP_W-1:0] FN_ADD   = 6'b100000;
    localparam logic [OP_W-1:0] FN_ADDU  = 6'b100001;
    localparam logic [OP_W-1:0] FN_SUB   = 6'b100010;
    localparam logic [OP_W-1:0] FN_SUBU  = 6'b100011;
    localparam logic [OP_W-1:0] FN_XOR   = 6'b100110;
    localparam logic [OP_W-1:0] FN_MULT  = 6'b011000;
    localparam logic [OP_W-1:0] FN_MULTU = 6'b011001;
    localparam logic [OP_W-1:0] FN_DIV   = 6'b011010;
    localparam logic [OP_W-1:0] FN_DIVU  = 6'b011011;
    localparam logic [OP_W-1:0] FN_MFHI  = 6'b010000;
    localparam logic [OP_W-1:0] FN_MFLO  = 6'b010010;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   wb_instr_q, wb_instr_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic              md_busy_q, md_busy_d;

    logic [OP_W-1:0]   opcode;
    logic [OP_W-1:0]   funct;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic              is_r;
    logic              is_alu_r;
    logic              is_md;
    logic              is_mfhi;
    logic              is_mflo;
    logic              is_addi;
    logic              is_lw;
    logic              is_lui;
    logic              dest_zero;
    logic              suppress;
    logic              accept;
    logic              emit;
    logic              md_fill;
    logic [XLEN-1:0]   hi_eff;
    logic [XLEN-1:0]   lo_eff;
    logic [XLEN-1:0]   sel_data;

    // Instruction decode of the MEM-stage word
    always_comb begin
        opcode   = mem_instruction[31:26];
        funct    = mem_instruction[5:0];
        rt       = mem_instruction[20:16];
        rd       = mem_instruction[15:11];
        is_r     = (opcode == OP_RTYPE);
        is_alu_r = is_r && (funct inside {FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_XOR});
        is_md    = is_r && (funct inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
        is_mfhi  = is_r && (funct == FN_MFHI);
        is_mflo  = is_r && (funct == FN_MFLO);
        is_addi  = (opcode == OP_ADDI);
        is_lw    = (opcode == OP_LW);
        is_lui   = (opcode == OP_LUI);
    end

    // Stall depends only on state, md_done and the instruction class
    assign stall   = (state_q == S_BUSY) && !md_done && mem_valid
                     && (is_md || is_mfhi || is_mflo);
    assign accept  = mem_valid && !stall;
    assign md_fill = (state_q == S_BUSY) && md_done;

    // A completing mult/div is forwarded to a same-cycle mfhi/mflo
    assign hi_eff = md_fill ? md_hi : hi_q;
    assign lo_eff = md_fill ? md_lo : lo_q;

    // Write data select
    always_comb begin
        sel_data = '0;
        if (is_alu_r || is_addi) begin
            sel_data = alu_result;
        end else if (is_lw) begin
            sel_data = mem_rdata;
        end else if (is_lui) begin
            sel_data = {mem_instruction[15:0], 16'h0000};
        end else if (is_mfhi) begin
            sel_data = hi_eff;
        end else if (is_mflo) begin
            sel_data = lo_eff;
        end
    end

    // Destination is rd for R-type writers, rt for I-type writers
    always_comb begin
        dest_zero = 1'b0;
        if (is_alu_r || is_mfhi || is_mflo) begin
            dest_zero = (rd == '0);
        end else if (is_addi || is_lw || is_lui) begin
            dest_zero = (rt == '0);
        end
    end

    assign suppress = ZERO_R0 && dest_zero;
    assign emit     = accept && !suppress;

    // Next-state: FSM, HI/LO fill and write-back pipeline register
    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        wb_instr_d = '0;
        data_d     = '0;

        if (md_fill) begin
            hi_d    = md_hi;
            lo_d    = md_lo;
            state_d = S_IDLE;
        end
        if (accept && is_md) begin
            state_d = S_BUSY;
        end
        if (emit) begin
            wb_instr_d = mem_instruction;
            data_d     = sel_data;
        end
        md_busy_d = (state_d == S_BUSY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            wb_instr_q <= '0;
            data_q     <= '0;
            md_busy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            wb_instr_q <= wb_instr_d;
            data_q     <= data_d;
            md_busy_q  <= md_busy_d;
        end
    end

    assign WBInstruction = wb_instr_q;
    assign DataOut       = data_q;
    assign md_busy       = md_busy_q;

`ifdef WB_RETIRE_COUNT_EN
    logic [CNT_W-1:0] retired_q, retired_d;

    // Counts emitted (non-bubble) write-backs, wrapping naturally
    always_comb begin
        retired_d = retired_q;
        if (emit) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired_count = retired_q;

    logic unused_bits;
    assign unused_bits = ^{mem_instruction[25:21], mem_instruction[10:6]};
`else
    logic unused_bits;
    assign unused_bits = ^{mem_instruction[25:21], mem_instruction[10:6], 32'(CNT_W)};
`endif

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage; drives the register file's write-back inputs (WBInstruction, DataOut).
- Latches the MEM-stage instruction and selects the write data: ALU result, load data, LUI immediate, or HI/LO.
- Owns the HI/LO registers, fills them from the multi-cycle multiply/divide unit, and adds mfhi/mflo support.
- Stalls upstream while a HI/LO result is still outstanding.

Parameters:
- ZERO_R0, 1: when 1, any write whose destination is register 0 is emitted as a bubble (32'h0).
- CNT_W, 32: width of the retire counter (Optional Feature only).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- mem_instruction  in  32  instruction leaving the MEM stage.
- mem_valid  in  1  mem_instruction is a real instruction, not a bubble.
- alu_result  in  32  ALU output for mem_instruction.
- mem_rdata  in  32  load data for mem_instruction.
- md_hi  in  32  HI result from the mult/div unit.
- md_lo  in  32  LO result from the mult/div unit.
- md_done  in  1  one-cycle pulse; md_hi/md_lo are valid this cycle.
- stall  out  1  combinational; upstream must hold mem_instruction.
- WBInstruction  out  32  registered; instruction presented to the register file.
- DataOut  out  32  registered; write data for WBInstruction.
- md_busy  out  1  registered; HI/LO result outstanding.

Behaviour:
- Opcodes:
  - R-type op 000000: add 100000, addu 100001, sub 100010, subu 100011, xor 100110, mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mflo 010010.
  - I-type: addi 001000, lw 100011, lui 001111.
- Reset: WBInstruction=0, DataOut=0, HI=0, LO=0, state IDLE, md_busy=0. Reset mid-operation discards any pending mult/div; a later md_done is ignored.
- Accept: instruction accepted on posedge when mem_valid=1 and stall=0.
  - Latency is 1 cycle: WBInstruction=mem_instruction, DataOut=selected value.
  - Otherwise WBInstruction=0 and DataOut=0 (bubble, no register write).
- DataOut select:
  - add/addu/sub/subu/xor/addi: alu_result.
  - lw: mem_rdata.
  - lui: {mem_instruction[15:0],16'h0}, computed here.
  - mfhi: HI. mflo: LO.
  - All others (beq, bne, j, sw, sll, mult/div): 0.
- ZERO_R0=1: if the destination field is 0, emit a bubble. Destination is rd[15:11] for R-type ALU/mfhi/mflo and rt[20:16] for addi/lw/lui.
- FSM:
  - IDLE -> BUSY: on accepting mult/multu/div/divu. md_busy=1 the next cycle. The instruction itself passes to WBInstruction with DataOut=0.
  - BUSY -> IDLE: on md_done. HI<=md_hi, LO<=md_lo.
  - md_done in IDLE is ignored.
- stall=1 when state=BUSY && md_done=0 && mem_valid && mem_instruction is mfhi/mflo/mult/multu/div/divu. All other instructions flow through during BUSY.
- Bypass: md_done=1 while mfhi/mflo is presented in BUSY means stall=0, the instruction is accepted, and DataOut=md_hi/md_lo (not the old HI/LO).
  - Same cycle with a new mult/div: HI/LO latch md results and the state stays BUSY.
- stall depends only on current inputs and state; no combinational path from mem_rdata/alu_result to stall.

Optional Feature:
- Macro: WB_RETIRE_COUNT_EN.
- Defined: extra output retired_count [CNT_W-1:0].
  - Reset 0.
  - +1 on every posedge that emits a non-bubble WBInstruction (ZERO_R0-suppressed writes not counted).
  - Wraps from all-ones to 0.
- Undefined: the port and counter are absent; all other behaviour identical.

Test Plan:
- Reset, then mem_valid=0 for 3 cycles -> WBInstruction=0, DataOut=0, stall=0, md_busy=0 each cycle.
- lw $5 (32'h8C05_0004), mem_rdata=32'hDEAD_BEEF -> next cycle WBInstruction=32'h8C05_0004, DataOut=32'hDEAD_BEEF.
- lui $3,0x1234 (32'h3C03_1234), alu_result=32'hFFFF_FFFF -> DataOut=32'h1234_0000.
- mult (32'h0085_0018), then mflo $2 (32'h0000_1012) held 4 cycles; md_done in cycle 4 with md_lo=32'h0000_0030:
  - stall=1 for cycles 1-3, WBInstruction=0 in those cycles.
  - Cycle 4: stall=0. Next cycle: DataOut=32'h0000_0030 (bypass).
  - md_busy=0 afterwards.
- ZERO_R0=1, addi $0 (32'h2000_0007) -> WBInstruction=0, DataOut=0. ZERO_R0=0 -> instruction passes with DataOut=alu_result.
- WB_RETIRE_COUNT_EN, CNT_W=4: 17 valid add instructions with nonzero rd -> retired_count reads 1 after wrapping; bubbles leave it unchanged.
